// File: rtl/tiny16_pkg.sv
// Shared tiny16 datapath constants: architectural register indices and PC-source encoding.
package tiny16_pkg;

    localparam int unsigned WIDTH_DEFAULT = 16;
    localparam int unsigned REG_SEL_W     = 3;

    localparam logic [REG_SEL_W-1:0] REG_PC   = 3'd0;
    localparam logic [REG_SEL_W-1:0] REG_LINK = 3'd1;
    localparam logic [REG_SEL_W-1:0] REG_TMP  = 3'd7;

    // Next-PC source, resolved by priority JMP > BR > LOAD > INC > HOLD
    typedef enum logic [2:0] {
        PC_SRC_HOLD = 3'd0,
        PC_SRC_INC  = 3'd1,
        PC_SRC_LOAD = 3'd2,
        PC_SRC_JMP  = 3'd3,
        PC_SRC_BR   = 3'd4
    } pc_src_e;

endpackage

// File: rtl/pc_unit.sv
// Program counter (r0) with the next-PC priority mux, incrementer and branch adder.
module pc_unit
    import tiny16_pkg::*;
#(
    parameter int unsigned         WIDTH    = WIDTH_DEFAULT,
    parameter logic [WIDTH-1:0]    RESET_PC = '0,
    parameter int unsigned         JMP_BITS = 12,
    parameter int unsigned         BR_BITS  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic             inc_en,
    input  logic             load_en,
    input  logic             jmp_en,
    input  logic             br_en,
    output logic [WIDTH-1:0] pc
);

    pc_src_e          pc_src;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] jmp_target;
    logic [WIDTH-1:0] br_offset;

    assign jmp_target = {{(WIDTH-JMP_BITS){1'b0}}, in[JMP_BITS-1:0]};
    assign br_offset  = {{(WIDTH-BR_BITS){in[BR_BITS-1]}}, in[BR_BITS-1:0]};

    always_comb begin
        pc_src = PC_SRC_HOLD;
        if (jmp_en)       pc_src = PC_SRC_JMP;
        else if (br_en)   pc_src = PC_SRC_BR;
        else if (load_en) pc_src = PC_SRC_LOAD;
        else if (inc_en)  pc_src = PC_SRC_INC;
    end

    // All arithmetic wraps modulo 2^WIDTH
    always_comb begin
        pc_next = pc;
        case (pc_src)
            PC_SRC_JMP:  pc_next = jmp_target;
            PC_SRC_BR:   pc_next = pc + br_offset;
            PC_SRC_LOAD: pc_next = in;
            PC_SRC_INC:  pc_next = pc + WIDTH'(1);
            default:     pc_next = pc;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pc <= RESET_PC;
        else      pc <= pc_next;
    end

endmodule

// File: rtl/register_file.sv
// tiny16 eight-entry register file: r0 lives in pc_unit, r1-r7 here, with combinational read ports.
module register_file
    import tiny16_pkg::*;
#(
    parameter int unsigned         WIDTH    = WIDTH_DEFAULT,
    parameter logic [WIDTH-1:0]    RESET_PC = '0,
    parameter int unsigned         JMP_BITS = 12,
    parameter int unsigned         BR_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     in,
    input  logic [REG_SEL_W-1:0] reg_src_sel,
    input  logic [REG_SEL_W-1:0] reg_dst_sel,
    input  logic                 reg_in_en,
    input  logic                 reg_pc_en,
    input  logic                 reg_jp_en,
    input  logic                 reg_br_en,
    input  logic                 reg_out_en,
    output logic [WIDTH-1:0]     out,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     pc,
    input  logic [REG_SEL_W-1:0] dbg_sel,
    output logic [WIDTH-1:0]     dbg_out
);

    logic [WIDTH-1:0] gpr [1:7];
    logic [WIDTH-1:0] rf  [8];
    logic             wr_gpr;
    logic             wr_pc;

    assign wr_gpr = reg_in_en && (reg_dst_sel != REG_PC);
    assign wr_pc  = reg_in_en && (reg_dst_sel == REG_PC);

    pc_unit #(
        .WIDTH    (WIDTH),
        .RESET_PC (RESET_PC),
        .JMP_BITS (JMP_BITS),
        .BR_BITS  (BR_BITS)
    ) u_pc_unit (
        .clk     (clk),
        .rst     (rst),
        .in      (in),
        .inc_en  (reg_pc_en),
        .load_en (wr_pc),
        .jmp_en  (reg_jp_en),
        .br_en   (reg_br_en),
        .pc      (pc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 1; i < 8; i++) gpr[i] <= '0;
        end else if (wr_gpr) begin
            gpr[reg_dst_sel] <= in;
        end
    end

    // Unified view so r0 reads through the same mux as r1-r7; no same-edge forwarding
    always_comb begin
        rf[0] = pc;
        for (int i = 1; i < 8; i++) rf[i] = gpr[i];
    end

    assign out       = reg_out_en ? rf[reg_src_sel] : '0;
    assign out_valid = reg_out_en;
    assign dbg_out   = rf[dbg_sel];

endmodule
